// File: rtl/sram_controller_pkg.sv
// Shared definitions for the external SRAM controller.
// Holds the FSM state encoding, the default CPU base address and the SRAM bus widths.
// No logic lives here.
package sram_controller_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int          SRAM_AW       = 18;
  localparam int          SRAM_DW       = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Settle-wait counter: cleared by load, advanced by en, tc flags cnt == TERM.
// Latency: tc is combinational from the registered count.
// Backpressure: none; the parent FSM decides when to load and advance.
// Ports: clk, rst (sync, active-high), load, en, tc.
module sram_wait_counter #(
  parameter int               CNT_W = 3,
  parameter logic [CNT_W-1:0] TERM  = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM cycles plus a settle wait.
// Latency: 3+WAIT_CYCLES cycles from request seen in IDLE to DONE; readData is registered.
// Backpressure: SRAM_NOT_READY freezes the pipeline while req is high, except in DONE.
// Ports: clk/rst; MEM_R_EN, MEM_W_EN, address, writeData in; readData, SRAM_NOT_READY out;
//        SRAM_DQ inout; SRAM_ADDR, SRAM_WE_N, SRAM_OE_N/CE_N/UB_N/LB_N (tied low) out.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          WAIT_CYCLES = 3,
  parameter int          CNT_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               SRAM_NOT_READY,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  // Last wait-counter value; WAIT_CYCLES == 0 never enters WAIT so the value is moot.
  localparam logic [CNT_W-1:0] CNT_TERM =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t             state, state_nxt;
  logic               req;
  logic               is_wr;
  logic               cnt_load, cnt_en, cnt_tc;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] word_hold;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic               unused_off;

  assign req = MEM_R_EN | MEM_W_EN;

  // Wrapping subtract: addresses below BASE_ADDR alias high in the SRAM, unchecked.
  assign off        = address - BASE_ADDR;
  assign unused_off = ^{off[31:19], off[1:0]};

  sram_wait_counter #(
    .CNT_W (CNT_W),
    .TERM  (CNT_TERM)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      readData  <= '0;
      word_hold <= '0;
    end else begin
      state <= state_nxt;
      // Write wins when both enables are high.
      if (state == S_IDLE && req) begin
        is_wr <= MEM_W_EN;
      end
      // The CPU may drop its request after HIGH, so keep the word address for WAIT/DONE.
      if (state == S_HIGH) begin
        word_hold <= off[18:2];
      end
      if (!is_wr && state == S_LOW) begin
        readData[15:0] <= SRAM_DQ;
      end
      if (!is_wr && state == S_HIGH) begin
        readData[31:16] <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = writeData[15:0];
    case (state)
      S_IDLE: begin
        if (req) state_nxt = S_LOW;
      end
      S_LOW: begin
        state_nxt = S_HIGH;
        SRAM_ADDR = {off[18:2], 1'b0};
        SRAM_WE_N = ~is_wr;
        dq_oe     = is_wr;
      end
      S_HIGH: begin
        state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        cnt_load  = 1'b1;
        SRAM_ADDR = {off[18:2], 1'b1};
        SRAM_WE_N = ~is_wr;
        dq_oe     = is_wr;
        dq_out    = writeData[31:16];
      end
      S_WAIT: begin
        cnt_en    = 1'b1;
        SRAM_ADDR = {word_hold, 1'b1};
        if (cnt_tc) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        SRAM_ADDR = {word_hold, 1'b1};
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  // The pipeline is released exactly in DONE.
  assign SRAM_NOT_READY = req & (state != S_DONE);

  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: word-level reference memory, per-cycle pin checks.
// Main instance uses WAIT_CYCLES=3 against a half-word SRAM model; a second
// instance with WAIT_CYCLES=0 reads from an address-derived data pattern.
module tb_sram_controller;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  wire  [31:0] readData;
  wire         nr;
  wire  [15:0] dq;
  wire  [17:0] sa;
  wire         we_n, oe_n, ce_n, ub_n, lb_n;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .writeData(writeData), .readData(readData),
    .SRAM_NOT_READY(nr), .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // Half-word SRAM model. A write cycle cut short by reset is not committed.
  logic [15:0] sram [0:255];
  bit          model_drive = 1'b0;
  assign dq = (model_drive && we_n) ? sram[sa[7:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n && !rst) sram[sa[7:0]] <= dq;

  // Second instance, no settle wait, read-only.
  logic        r0 = 1'b0;
  logic [31:0] a0 = '0;
  wire  [31:0] rd0;
  wire         nr0;
  wire  [15:0] dq0;
  wire  [17:0] sa0;
  wire         we0, oe0, ce0, ub0, lb0;
  assign dq0 = we0 ? (sa0[15:0] ^ 16'hA5C3) : 16'hzzzz;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(0), .CNT_W(1)) u_dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(1'b0),
    .address(a0), .writeData(32'h0), .readData(rd0),
    .SRAM_NOT_READY(nr0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0),
    .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );

  // Reference: 32-bit words as the CPU sees them, plus the last load result.
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rd = '0;
  int          n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Nobody drives the bus (reads as z, or 0 on a two-state simulator).
  function automatic logic [31:0] driven(input logic [15:0] v);
    return (v === 16'hzzzz || v === 16'h0000) ? 32'd0 : 32'd1;
  endfunction

  task automatic acc(input bit rd, input bit wr, input int idx, input logic [31:0] wd);
    bit          done;
    logic [17:0] lo, hi;
    done = 1'b0;
    lo   = 18'(2 * idx);
    hi   = 18'(2 * idx + 1);
    if (!wr) exp_rd = ref_mem[idx];
    @(posedge clk); #1;
    MEM_R_EN = rd; MEM_W_EN = wr; address = BASE + 32'(4 * idx); writeData = wd;
    model_drive = !wr;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!nr) begin
        done = 1'b1;
        chk("stall_cycles", 32'(k), 32'(3 + W));
        chk("done_addr", 32'(sa), 32'(hi));
        chk("done_we_n", 32'(we_n), 1);
        chk("read_data", readData, exp_rd);
      end else if (k == 0) begin
        chk("idle_addr", 32'(sa), 0);
        chk("idle_we_n", 32'(we_n), 1);
      end else if (k < 3) begin
        chk("half_addr", 32'(sa), 32'((k == 1) ? lo : hi));
        chk("half_we_n", 32'(we_n), 32'(!wr));
        if (wr) chk("half_dq", 32'(dq), 32'((k == 1) ? wd[15:0] : wd[31:16]));
      end else begin
        chk("wait_addr", 32'(sa), 32'(hi));
        chk("wait_we_n", 32'(we_n), 1);
        if (wr) chk("wait_dq_z", driven(dq), 0);
      end
    end
    if (!done) chk("access_timeout", 0, 1);
    if (wr) ref_mem[idx] = wd;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; model_drive = 1'b1;
  endtask

  task automatic acc0(input int idx);
    bit          done;
    logic [17:0] lo, hi;
    logic [31:0] e;
    done = 1'b0;
    lo   = 18'(2 * idx);
    hi   = 18'(2 * idx + 1);
    e    = {hi[15:0] ^ 16'hA5C3, lo[15:0] ^ 16'hA5C3};
    @(posedge clk); #1;
    r0 = 1'b1; a0 = BASE + 32'(4 * idx);
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (!nr0) begin
        done = 1'b1;
        chk("w0_stall_cycles", 32'(k), 3);
        chk("w0_read_data", rd0, e);
      end else if (k == 2) begin
        chk("w0_high_addr", 32'(sa0), 32'(hi));
      end
    end
    if (!done) chk("w0_timeout", 0, 1);
    @(posedge clk); #1;
    r0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, nv;
    int          op;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      sram[2*i]     <= v[15:0];
      sram[2*i + 1] <= v[31:16];
    end
    ref_mem[2] = 32'h22221111;
    sram[4] <= 16'h1111;
    sram[5] <= 16'h2222;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", readData, 0);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_addr", 32'(sa), 0);
    chk("rst_not_ready", 32'(nr), 0);
    chk("rst_dq_z", driven(dq), 0);
    chk("rst_ties", 32'({oe_n, ce_n, ub_n, lb_n}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_drive = 1'b1;

    // Store then load
    acc(1'b0, 1'b1, 0, 32'hDEADBEEF); idle();
    acc(1'b1, 1'b0, 0, 32'h0);        idle();
    // Address map: 1032 -> SRAM 4/5
    acc(1'b1, 1'b0, 2, 32'h0);        idle();
    // Back-to-back loads with req held
    acc(1'b1, 1'b0, 5, 32'h0);
    acc(1'b1, 1'b0, 9, 32'h0);        idle();
    // Both enables: a write, readData untouched
    acc(1'b1, 1'b1, 7, 32'hCAFEF00D); idle();
    acc(1'b1, 1'b0, 7, 32'h0);        idle();

    // Reset in HIGH of a write: low half lands, high half does not
    nv = 32'hA5A55A5A;
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; address = BASE + 32'd44; writeData = nv; model_drive = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(negedge clk);
    chk("high_we_n_before_rst", 32'(we_n), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_we_n", 32'(we_n), 1);
    chk("mid_rst_dq_z", driven(dq), 0);
    chk("mid_rst_read_data", readData, 0);
    chk("mid_rst_addr", 32'(sa), 0);
    chk("mid_rst_not_ready", 32'(nr), 0);
    ref_mem[11] = {ref_mem[11][31:16], nv[15:0]};
    exp_rd = '0;
    idle();
    acc(1'b1, 1'b0, 11, 32'h0); idle();

    // Random mix of loads, stores, both-high, with and without gaps
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 3);
      acc(op != 2, op >= 2, $urandom_range(0, 63), $urandom);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // No settle wait
    acc0(0);
    acc0(3);
    acc0($urandom_range(0, 63));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
